// File: rtl/tia_pkg.sv
// Shared constants and types for the TIA CPU clocking slice.
// Line geometry, divide-by-three phase count and WSYNC states.
package tia_pkg;

  localparam int TIA_LINE_CLOCKS   = 228;
  localparam int TIA_HBLANK_CLOCKS = 68;
  localparam int TIA_PHASES        = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wsync_state_t;

endpackage

// File: rtl/tia_hcounter.sv
// Horizontal position counter: wrap, RSYNC load, line_start pulse and optional hblank.
// 1-cycle latency from rsync_strobe to hcount; no backpressure, runs every clk.
module tia_hcounter
  import tia_pkg::*;
#(
  parameter int LINE_CLOCKS = TIA_LINE_CLOCKS,
  parameter int RSYNC_LOAD  = LINE_CLOCKS - 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rsync_strobe,
  output logic [7:0] hcount,
  output logic       line_start,
  output logic       line_wrap
`ifdef TIA_CPU_CLK_HBLANK_EN
  , output logic     hblank
`endif
);

  localparam logic [7:0] HC_LAST = 8'(LINE_CLOCKS - 1);
  localparam logic [7:0] HC_LOAD = 8'(RSYNC_LOAD);

  logic [7:0] hcount_q, hcount_d;
  logic       line_start_q, line_start_d;

  always_comb begin
    hcount_d = hcount_q + 8'd1;
    if (rsync_strobe) begin
      hcount_d = HC_LOAD;
    end else if (hcount_q == HC_LAST) begin
      hcount_d = 8'd0;
    end
    // Only a wrap (natural or RSYNC-forced) starts a line, never reset.
    line_start_d = (hcount_d == 8'd0) && (rsync_strobe || (hcount_q == HC_LAST));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q     <= 8'd0;
      line_start_q <= 1'b0;
    end else begin
      hcount_q     <= hcount_d;
      line_start_q <= line_start_d;
    end
  end

  assign hcount     = hcount_q;
  assign line_start = line_start_q;
  assign line_wrap  = line_start_d;

`ifdef TIA_CPU_CLK_HBLANK_EN
  logic hblank_q, hblank_d;

  always_comb begin
    hblank_d = (hcount_d < 8'(TIA_HBLANK_CLOCKS));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hblank_q <= 1'b1;
    end else begin
      hblank_q <= hblank_d;
    end
  end

  assign hblank = hblank_q;
`endif

endmodule

// File: rtl/tia_cpu_clock_controller.sv
// CPU clock sequencer: phi0 phase enable, RESPHI0 pulse, WSYNC stall; 1-cycle strobe latency.
// rdy is the CPU backpressure; optional hblank output under TIA_CPU_CLK_HBLANK_EN.
module tia_cpu_clock_controller
  import tia_pkg::*;
#(
  parameter int LINE_CLOCKS = TIA_LINE_CLOCKS,
  parameter int RSYNC_LOAD  = LINE_CLOCKS - 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wsync_strobe,
  input  logic       rsync_strobe,
  input  logic       resphi0_req,
  output logic       phi0_en,
  output logic       resphi0,
  output logic       rdy,
  output logic       line_start,
  output logic [7:0] hcount
`ifdef TIA_CPU_CLK_HBLANK_EN
  , output logic     hblank
`endif
);

  localparam logic [1:0] PHASE_LAST = 2'(TIA_PHASES - 1);

  logic [1:0]   phase_q, phase_d;
  logic         resphi0_q, resphi0_d;
  wsync_state_t state_q, state_d;
  logic         line_wrap;

  tia_hcounter #(
    .LINE_CLOCKS (LINE_CLOCKS),
    .RSYNC_LOAD  (RSYNC_LOAD)
  ) u_hcounter (
    .clk          (clk),
    .reset_n      (reset_n),
    .rsync_strobe (rsync_strobe),
    .hcount       (hcount),
    .line_start   (line_start),
    .line_wrap    (line_wrap)
`ifdef TIA_CPU_CLK_HBLANK_EN
    , .hblank     (hblank)
`endif
  );

  always_comb begin
    phase_d   = (phase_q == PHASE_LAST) ? 2'd0 : phase_q + 2'd1;
    resphi0_d = resphi0_req;
    if (resphi0_req) begin
      phase_d = 2'd0;
    end

    // IDLE always accepts the strobe, so a strobe on the wrap cycle stalls a full line.
    state_d = state_q;
    case (state_q)
      IDLE:    if (wsync_strobe) state_d = WAIT;
      WAIT:    if (line_wrap)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q   <= 2'd0;
      resphi0_q <= 1'b0;
      state_q   <= IDLE;
    end else begin
      phase_q   <= phase_d;
      resphi0_q <= resphi0_d;
      state_q   <= state_d;
    end
  end

  assign phi0_en = (phase_q == PHASE_LAST);
  assign resphi0 = resphi0_q;
  assign rdy     = (state_q == IDLE);

endmodule
